// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and types
// for the register file slice.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_resp_buf.sv
// regfile_resp_buf: one-entry read response
// buffer with valid/ready and accept logic.
module regfile_resp_buf
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              rd_accept,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  assign rd_accept = rd_req & (~rd_valid | rd_ready);

  // load on accept, drop valid when drained, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      rd_data  <= load_data;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_rw.sv
// regfile_rw: register file with posted writes
// and a latency-1 valid/ready read port.
module regfile_rw
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_accept,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              zero_wr;
  logic              zero_rd;
  logic              bypass;
  logic [DATA_W-1:0] rd_word;

  assign zero_wr = (ZERO_REG != 0) && (wr_addr == '0);
  assign zero_rd = (ZERO_REG != 0) && (rd_addr == '0);
  assign bypass  = wr_en && !zero_wr && (wr_addr == rd_addr);

  // read word with write-first forwarding
  always_comb begin
    rd_word = mem[rd_addr];
    if (zero_rd)
      rd_word = '0;
    else if (bypass)
      rd_word = wr_data;
  end

  // storage: cleared on reset, entry 0 pinned when zero-reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en && !zero_wr) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_resp_buf #(
    .DATA_W(DATA_W)
  ) u_resp_buf (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_ready  (rd_ready),
    .load_data (rd_word),
    .rd_accept (rd_accept),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_regfile_rw.sv
// tb_regfile_rw: directed checks of the
// register file write and read-response paths.
module tb_regfile_rw;
  import regfile_pkg::*;

  logic  clk;
  logic  reset;
  logic  wr_en;
  addr_t wr_addr;
  data_t wr_data;
  logic  rd_req;
  addr_t rd_addr;
  logic  rd_accept;
  logic  rd_valid;
  data_t rd_data;
  logic  rd_ready;

  int tests = 0;
  int fails = 0;

  regfile_rw dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_accept (rd_accept),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_req  = 1'b0;
    rd_addr = '0;
    rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #12;
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %b exp 0", rd_valid);
    end
    tests++;
    if (rd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data got %h exp 00", rd_data);
    end
    tests++;
    if (rd_accept !== 1'b0) begin
      fails++;
      $display("FAIL reset_accept got %b exp 0", rd_accept);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_after_reset();
    rd_req = 1'b1;
    rd_addr = 3'd5;
    #1;
    tests++;
    if (rd_accept !== 1'b1) begin
      fails++;
      $display("FAIL rar_accept got %b exp 1", rd_accept);
    end
    tick();
    rd_req = 1'b0;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      fails++;
      $display("FAIL rar_resp got v=%b d=%h exp v=1 d=00",
               rd_valid, rd_data);
    end
    tick();
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rar_drain got v=%b exp v=0", rd_valid);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1;
    wr_addr = 3'd3;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    rd_req = 1'b1;
    rd_addr = 3'd3;
    tick();
    rd_req = 1'b0;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      fails++;
      $display("FAIL wr_rd got v=%b d=%h exp v=1 d=a5",
               rd_valid, rd_data);
    end
    tick();
    tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
      fails++;
      $display("FAIL wr_rd_hold got v=%b d=%h exp v=0 d=a5",
               rd_valid, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    addr_t a [3];
    data_t e [3];
    a[0] = 3'd1; e[0] = 8'h11;
    a[1] = 3'd2; e[1] = 8'h22;
    a[2] = 3'd3; e[2] = 8'hA5;
    wr_en = 1'b1;
    wr_addr = 3'd1;
    wr_data = 8'h11;
    tick();
    wr_addr = 3'd2;
    wr_data = 8'h22;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1;
      rd_addr = a[i];
      #1;
      tests++;
      if (rd_accept !== 1'b1) begin
        fails++;
        $display("FAIL b2b_accept[%0d] got %b exp 1",
                 i, rd_accept);
      end
      tick();
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== e[i]) begin
        fails++;
        $display("FAIL b2b_data[%0d] got v=%b d=%h exp v=1 d=%h",
                 i, rd_valid, rd_data, e[i]);
      end
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1;
    wr_addr = 3'd6;
    wr_data = 8'h3C;
    rd_req = 1'b1;
    rd_addr = 3'd6;
    tick();
    wr_en = 1'b0;
    rd_req = 1'b0;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      fails++;
      $display("FAIL bypass got v=%b d=%h exp v=1 d=3c",
               rd_valid, rd_data);
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tests++;
    if (rd_data !== 8'h3C) begin
      fails++;
      $display("FAIL bypass_stored got %h exp 3c", rd_data);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    rd_req = 1'b1;
    rd_addr = 3'd0;
    tick();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      fails++;
      $display("FAIL zero_rd got v=%b d=%h exp v=1 d=00",
               rd_valid, rd_data);
    end
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    rd_req = 1'b0;
    tests++;
    if (rd_data !== 8'h00) begin
      fails++;
      $display("FAIL zero_bypass got %h exp 00", rd_data);
    end
    tick();
  endtask

  task automatic test_stall();
    rd_req = 1'b1;
    rd_addr = 3'd3;
    rd_ready = 1'b0;
    tick();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      fails++;
      $display("FAIL stall_load got v=%b d=%h exp v=1 d=a5",
               rd_valid, rd_data);
    end
    for (int k = 0; k < 3; k++) begin
      wr_en = (k == 0);
      wr_addr = 3'd3;
      wr_data = 8'h5A;
      #1;
      tests++;
      if (rd_accept !== 1'b0) begin
        fails++;
        $display("FAIL stall_accept[%0d] got %b exp 0",
                 k, rd_accept);
      end
      tick();
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
        fails++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h exp v=1 d=a5",
                 k, rd_valid, rd_data);
      end
    end
    wr_en = 1'b0;
    rd_ready = 1'b1;
    #1;
    tests++;
    if (rd_accept !== 1'b1) begin
      fails++;
      $display("FAIL stall_release got %b exp 1", rd_accept);
    end
    tick();
    rd_req = 1'b0;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
      fails++;
      $display("FAIL stall_new got v=%b d=%h exp v=1 d=5a",
               rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    wr_en = 1'b1;
    wr_addr = 3'd2;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_req = 1'b1;
    rd_addr = 3'd2;
    rd_ready = 1'b0;
    tick();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin
      fails++;
      $display("FAIL rms_pre got v=%b d=%h exp v=1 d=77",
               rd_valid, rd_data);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      fails++;
      $display("FAIL rms_async got v=%b d=%h exp v=0 d=00",
               rd_valid, rd_data);
    end
    wr_en = 1'b1;
    wr_addr = 3'd4;
    wr_data = 8'h44;
    rd_ready = 1'b1;
    tick();
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rms_held got v=%b exp v=0", rd_valid);
    end
    wr_en = 1'b0;
    rd_req = 1'b0;
    #2;
    reset = 1'b0;
    rd_req = 1'b1;
    rd_addr = 3'd2;
    tick();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      fails++;
      $display("FAIL rms_rd2 got v=%b d=%h exp v=1 d=00",
               rd_valid, rd_data);
    end
    rd_addr = 3'd4;
    tick();
    rd_req = 1'b0;
    tests++;
    if (rd_data !== 8'h00) begin
      fails++;
      $display("FAIL rms_rd4 got %h exp 00", rd_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_back_to_back();
    test_bypass();
    test_zero_reg();
    test_stall();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
